// File: rtl/zigzag_runlevel_4x4.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_runlevel_4x4
// Purpose  : Captures one 4x4 block of quantized coefficients, walks it in
//            zig-zag order and streams only the nonzero coefficients as
//            (run, level) beats. The final beat of a block carries out_last;
//            an all-zero block produces a single empty beat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   mode       in   intra(1)/inter(0) flag, captured with the block
//   in_coeffs  in   16 signed coefficients, row-major (row*4+col)
//   in_valid   in   in_coeffs/mode valid
//   in_ready   out  block can be accepted (IDLE only)
//   out_level  out  signed nonzero coefficient
//   out_run    out  zeros skipped since previous beat / block start
//   out_last   out  final beat of the block
//   out_empty  out  block had no nonzero coefficient (with out_last)
//   out_total  out  nonzero coefficient count, 0..16
//   out_mode   out  captured mode
//   out_valid  out  beat valid
//   out_ready  in   downstream accepts the beat
// ----------------------------------------------------------------------------
// Build option
//   ZIGZAG_REVERSE_SCAN_EN : when defined, traversal runs from zig-zag
//                            position 15 down to 0 (CAVLC order).
// ============================================================================
module zigzag_runlevel_4x4 #(
   parameter int BIT_LENGTH = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mode,
   input  logic signed [BIT_LENGTH:0]   in_coeffs [15:0],
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [BIT_LENGTH:0]   out_level,
   output logic [3:0]                   out_run,
   output logic                         out_last,
   output logic                         out_empty,
   output logic [4:0]                   out_total,
   output logic                         out_mode,
   output logic                         out_valid,
   input  logic                         out_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                     state;
   // Coefficients and nonzero mask are stored already permuted into
   // traversal order, so the scan simply steps pos 0..15.
   logic signed [BIT_LENGTH:0] coef_q [15:0];
   logic [15:0]                nz_q;
   logic [3:0]                 last_pos_q;
   logic [3:0]                 pos_q;
   logic [3:0]                 run_q;

   logic [15:0]                cap_nz;
   logic [4:0]                 cap_total;
   logic [3:0]                 cap_last;
   logic                       advance;

   // Row-major index of the coefficient at forward zig-zag position p.
   function automatic logic [3:0] zz_index(input logic [3:0] p);
      logic [3:0] idx;
      case (p)
         4'd0:    idx = 4'd0;
         4'd1:    idx = 4'd1;
         4'd2:    idx = 4'd4;
         4'd3:    idx = 4'd8;
         4'd4:    idx = 4'd5;
         4'd5:    idx = 4'd2;
         4'd6:    idx = 4'd3;
         4'd7:    idx = 4'd6;
         4'd8:    idx = 4'd9;
         4'd9:    idx = 4'd12;
         4'd10:   idx = 4'd13;
         4'd11:   idx = 4'd10;
         4'd12:   idx = 4'd7;
         4'd13:   idx = 4'd11;
         4'd14:   idx = 4'd14;
         default: idx = 4'd15;
      endcase
      return idx;
   endfunction

   // Row-major index of the coefficient visited at traversal position p.
   function automatic logic [3:0] trav_index(input logic [3:0] p);
`ifdef ZIGZAG_REVERSE_SCAN_EN
      return zz_index(4'd15 - p);
`else
      return zz_index(p);
`endif
   endfunction

   // Block statistics computed directly from the incoming block so they are
   // ready at the capture edge.
   always_comb begin
      cap_nz    = '0;
      cap_total = '0;
      cap_last  = '0;
      for (int p = 0; p < 16; p++) begin
         if (in_coeffs[trav_index(4'(p))] != '0) begin
            cap_nz[p] = 1'b1;
            cap_total = cap_total + 5'd1;
            cap_last  = 4'(p);
         end
      end
   end

   // The scan may proceed unless a beat is held and not being taken.
   assign advance = !(out_valid && !out_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_level  <= '0;
         out_run    <= '0;
         out_last   <= 1'b0;
         out_empty  <= 1'b0;
         out_total  <= '0;
         out_mode   <= 1'b0;
         nz_q       <= '0;
         last_pos_q <= '0;
         pos_q      <= '0;
         run_q      <= '0;
         for (int i = 0; i < 16; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < 16; i++) begin
                     coef_q[i] <= in_coeffs[trav_index(4'(i))];
                  end
                  nz_q       <= cap_nz;
                  last_pos_q <= cap_last;
                  out_total  <= cap_total;
                  out_mode   <= mode;
                  out_empty  <= 1'b0;
                  pos_q      <= '0;
                  run_q      <= '0;
                  in_ready   <= 1'b0;
                  state      <= (cap_nz == '0) ? S_FLUSH : S_SCAN;
               end
            end

            S_SCAN: begin
               if (advance) begin
                  if (nz_q[pos_q]) begin
                     out_level <= coef_q[pos_q];
                     out_run   <= run_q;
                     out_last  <= (pos_q == last_pos_q);
                     out_valid <= 1'b1;
                     run_q     <= '0;
                     if (pos_q == last_pos_q) begin
                        state <= S_DRAIN;
                     end
                  end else begin
                     // Zero: any held beat is being accepted this edge.
                     run_q     <= run_q + 4'd1;
                     out_valid <= 1'b0;
                  end
                  pos_q <= pos_q + 4'd1;
               end
            end

            S_FLUSH: begin
               out_level <= '0;
               out_run   <= '0;
               out_last  <= 1'b1;
               out_empty <= 1'b1;
               out_total <= '0;
               out_valid <= 1'b1;
               state     <= S_DRAIN;
            end

            default: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_runlevel_4x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_runlevel_4x4
// Purpose  : Self-checking bench for zigzag_runlevel_4x4. Expected beats come
//            from a reference model that walks the block in scan order and
//            emits (run, level) pairs; table vectors, directed latency/reset
//            sequences and random blocks are all checked against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_runlevel_4x4;

   localparam int BL = 15;

   typedef logic signed [BL:0] blk_t [15:0];

   typedef struct {
      logic [15:0] level;
      logic [3:0]  run;
      logic        last;
      logic        empty;
      logic [4:0]  total;
      logic        mode;
   } beat_t;

   typedef struct {
      blk_t        c;
      logic        m;
      int          rp;
      int          exp_n;
      int          exp_total;
      logic [15:0] f_level;
      int          f_run;
      logic [15:0] l_level;
      int          l_run;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mode = 1'b0;
   blk_t        in_coeffs;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic signed [BL:0] out_level;
   logic [3:0]  out_run;
   logic        out_last;
   logic        out_empty;
   logic [4:0]  out_total;
   logic        out_mode;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   beat_t exp_q[$];
   beat_t obs[$];
   int    zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

   zigzag_runlevel_4x4 #(.BIT_LENGTH(BL)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .in_coeffs (in_coeffs),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_level (out_level),
      .out_run   (out_run),
      .out_last  (out_last),
      .out_empty (out_empty),
      .out_total (out_total),
      .out_mode  (out_mode),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input beat_t b);
      return {4'd0, b.level, b.run, b.last, b.empty, b.total, b.mode};
   endfunction

   function automatic beat_t sample_out();
      beat_t b;
      b.level = $unsigned(out_level);
      b.run   = out_run;
      b.last  = out_last;
      b.empty = out_empty;
      b.total = out_total;
      b.mode  = out_mode;
      return b;
   endfunction

   // Reference: visit coefficients in scan order, count zeros between
   // nonzero values, mark the k-th of 'total' nonzeros as last.
   task automatic build_model(input blk_t c, input logic m);
      int    total;
      int    run;
      int    k;
      int    idx;
      beat_t b;
      exp_q.delete();
      total = 0;
      for (int i = 0; i < 16; i++) if (c[i] != 0) total++;
      if (total == 0) begin
         b.level = '0; b.run = '0; b.last = 1'b1; b.empty = 1'b1;
         b.total = '0; b.mode = m;
         exp_q.push_back(b);
      end else begin
         run = 0;
         k   = 0;
         for (int p = 0; p < 16; p++) begin
`ifdef ZIGZAG_REVERSE_SCAN_EN
            idx = zz[15 - p];
`else
            idx = zz[p];
`endif
            if (c[idx] == 0) begin
               run++;
            end else if (k < total) begin
               k++;
               b.level = c[idx];
               b.run   = 4'(run);
               b.last  = (k == total);
               b.empty = 1'b0;
               b.total = 5'(total);
               b.mode  = m;
               exp_q.push_back(b);
               run = 0;
            end
         end
      end
   endtask

   task automatic drive_block(input blk_t c, input logic m);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL in_ready_wait: got 0 expected 1");
      end
      in_coeffs = c;
      mode      = m;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // rp: 0 = out_ready tied high, 1 = toggling 1,0,1,0..., 2 = random.
   task automatic run_block(input blk_t c, input logic m, input int rp);
      beat_t cur;
      beat_t hb;
      beat_t e;
      bit    held;
      bit    done;
      int    cyc;
      int    n_exp;
      build_model(c, m);
      n_exp = exp_q.size();
      obs.delete();
      drive_block(c, m);
      held = 1'b0;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         out_ready = (rp == 0) ? 1'b1 : (rp == 1) ? cyc[0] : 1'($urandom_range(0, 1));
         cur = sample_out();
         if (held) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_stable", pack(cur), pack(hb));
         end
         if (out_valid && out_ready) begin
            obs.push_back(cur);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat_level", 32'(cur.level), 32'(e.level));
               chk("beat_run",   32'(cur.run),   32'(e.run));
               chk("beat_last",  32'(cur.last),  32'(e.last));
               chk("beat_total", 32'(cur.total), 32'(e.total));
               chk("beat_mode",  32'(cur.mode),  32'(e.mode));
               if (e.last) chk("beat_empty", 32'(cur.empty), 32'(e.empty));
            end else begin
               checks++; failures++;
               $display("FAIL extra_beat: got level 0x%0h expected no beat", cur.level);
            end
            if (cur.last) done = 1'b1;
         end
         held = out_valid && !out_ready;
         hb   = cur;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL block_timeout: got %0d beats expected %0d", obs.size(), n_exp);
      end
      chk("beat_count", 32'(obs.size()), 32'(n_exp));
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after", 32'(in_ready), 32'd1);
      chk("valid_after",    32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   vec_t  tbl[7];
   blk_t  blk;
   int    nacc;
   int    guard;

   task automatic set_exp(input int i, input logic [15:0] fl, input int fr,
                          input logic [15:0] ll, input int lr);
      tbl[i].f_level = fl; tbl[i].f_run = fr;
      tbl[i].l_level = ll; tbl[i].l_run = lr;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) in_coeffs[i] = '0;

      // ---- table setup ----
      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < 16; i++) tbl[t].c[i] = '0;
         tbl[t].m  = t[0];
         tbl[t].rp = 0;
      end
      tbl[0].c[0] = 16'sd5;                        tbl[0].exp_n = 1;  tbl[0].exp_total = 1;
      /* tbl[1] all zero */                         tbl[1].exp_n = 1;  tbl[1].exp_total = 0;
      tbl[2].c[1] = -16'sd3; tbl[2].c[15] = 16'sd1; tbl[2].exp_n = 2;  tbl[2].exp_total = 2;
      for (int i = 0; i < 16; i++) tbl[3].c[i] = 16'sd1;
      tbl[3].rp = 1;                                tbl[3].exp_n = 16; tbl[3].exp_total = 16;
      tbl[4].c[15] = -16'sd1;                       tbl[4].exp_n = 1;  tbl[4].exp_total = 1;
      tbl[5].c[3] = 16'sd9; tbl[5].c[12] = -16'sd2; tbl[5].exp_n = 2;  tbl[5].exp_total = 2;
      tbl[5].rp = 1;
      tbl[6].c[0] = 16'sd2; tbl[6].c[4] = 16'sd7;   tbl[6].exp_n = 2;  tbl[6].exp_total = 2;
`ifdef ZIGZAG_REVERSE_SCAN_EN
      set_exp(0, 16'h0005, 15, 16'h0005, 15);
      set_exp(1, 16'h0000, 0,  16'h0000, 0);
      set_exp(2, 16'h0001, 0,  16'hFFFD, 13);
      set_exp(3, 16'h0001, 0,  16'h0001, 0);
      set_exp(4, 16'hFFFF, 0,  16'hFFFF, 0);
      set_exp(5, 16'hFFFE, 6,  16'h0009, 2);
      set_exp(6, 16'h0007, 13, 16'h0002, 1);
`else
      set_exp(0, 16'h0005, 0,  16'h0005, 0);
      set_exp(1, 16'h0000, 0,  16'h0000, 0);
      set_exp(2, 16'hFFFD, 1,  16'h0001, 13);
      set_exp(3, 16'h0001, 0,  16'h0001, 0);
      set_exp(4, 16'hFFFF, 15, 16'hFFFF, 15);
      set_exp(5, 16'h0009, 6,  16'hFFFE, 2);
      set_exp(6, 16'h0002, 0,  16'h0007, 1);
`endif

      // ---- reset state ----
      #12;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs",   {4'd0, $unsigned(out_level), out_run, out_last, out_empty, out_total, out_mode}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---- latency: single coefficient at position 0, ready tied high ----
      for (int i = 0; i < 16; i++) blk[i] = '0;
`ifdef ZIGZAG_REVERSE_SCAN_EN
      blk[15] = 16'sd5;
`else
      blk[0] = 16'sd5;
`endif
      out_ready = 1'b1;
      drive_block(blk, 1'b1);
      @(negedge clk);
      chk("lat_valid_t1", 32'(out_valid), 32'd0);
      chk("lat_busy",     32'(in_ready),  32'd0);
      @(negedge clk);
      chk("lat_valid_t2", 32'(out_valid), 32'd1);
      chk("lat_beat", pack(sample_out()), {4'd0, 16'h0005, 4'd0, 1'b1, 1'b0, 5'd1, 1'b1});
      @(negedge clk);
      chk("lat_done_valid", 32'(out_valid), 32'd0);
      chk("lat_in_ready",   32'(in_ready),  32'd1);
      out_ready = 1'b0;

      // ---- table vectors ----
      for (int t = 0; t < 7; t++) begin
         run_block(tbl[t].c, tbl[t].m, tbl[t].rp);
         chk("tbl_n", 32'(obs.size()), 32'(tbl[t].exp_n));
         if (obs.size() > 0) begin
            chk("tbl_total",   32'(obs[0].total), 32'(tbl[t].exp_total));
            chk("tbl_f_level", 32'(obs[0].level), 32'(tbl[t].f_level));
            chk("tbl_f_run",   32'(obs[0].run),   32'(tbl[t].f_run));
            chk("tbl_l_level", 32'(obs[obs.size()-1].level), 32'(tbl[t].l_level));
            chk("tbl_l_run",   32'(obs[obs.size()-1].run),   32'(tbl[t].l_run));
            chk("tbl_l_empty", 32'(obs[obs.size()-1].empty), 32'(tbl[t].exp_total == 0));
         end
      end

      // ---- reset mid-scan after two accepted beats ----
      for (int i = 0; i < 16; i++) blk[i] = 16'sd1;
      out_ready = 1'b1;
      drive_block(blk, 1'b0);
      nacc  = 0;
      guard = 0;
      while (nacc < 2 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (out_valid && out_ready) nacc++;
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid",    32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
      chk("mid_rst_total",    32'(out_total), 32'd0);
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[1] = -16'sd3; blk[15] = 16'sd1;
      run_block(blk, 1'b1, 0);

      // ---- random blocks ----
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 16; i++) begin
            if ((r % 8) != 0 && $urandom_range(0, 99) < 35) begin
               blk[i] = 16'($urandom);
               if (blk[i] == 0) blk[i] = -16'sd1;
            end else begin
               blk[i] = '0;
            end
         end
         run_block(blk, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
